serial_out_arbiter: RTL and testbench
=====================================

Name: serial_out_arbiter

Overview:
- Shares one serial output buffer (7-bit address + 8-bit data frame serializer with Go strobe) between NREQ parallel requesters.
- Arbitrates with a rotating (round-robin) priority and issues exactly one Go pulse per frame.
- Holds the selected A/D stable for the whole frame.
- Counts frame duration so a new Go never lands inside a frame in flight.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 7, address width per request
- DW, 8, data width per request
- FRAME_CYCLES, 20, clk_in cycles from one Go to the earliest next Go (>=2); 20 covers start + 7 A + Z + 8 D + Z + end plus margin
- IDW, local, $clog2(NREQ), grant index width

Ports:
- clk_in  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester request level; held high until the matching ack
- req_a  in  NREQ*AW  packed addresses; requester i uses slice [i*AW +: AW]
- req_d  in  NREQ*DW  packed data; requester i uses slice [i*DW +: DW]
- ack  out  NREQ  one-hot, one-cycle pulse to the granted requester, coincident with ser_go
- ser_go  out  1  one-cycle Go strobe to the serializer
- ser_a  out  AW  address to the serializer
- ser_d  out  DW  data to the serializer
- busy  out  1  high from the Go cycle to the last cycle of the frame
- grant_id  out  IDW  index of the last granted requester

Behaviour:
- Reset: when reset_n=0 at a clock edge, set state=IDLE, ack=0, ser_go=0, ser_a=0, ser_d=0, busy=0, grant_id=0, cnt=0, rr pointer=0. Reset wins over any request. Reset mid-frame aborts the wait immediately; the next Go after release is allowed one cycle after a req is seen.
- All outputs are registered.
- State machine, three states: IDLE, GO, WAIT.
- IDLE:
  - If req is nonzero, choose a winner, load ser_a/ser_d from its slices, set grant_id, and go to GO.
  - Otherwise stay in IDLE.
- GO (lasts 1 cycle):
  - ser_go=1, ack[winner]=1, busy=1.
  - Load cnt=FRAME_CYCLES-2, then go to WAIT.
- WAIT:
  - ser_go=0, ack=0, busy=1, cnt decrements by 1.
  - When cnt=0, arbitrate on the current req: if any bit is set, load the new winner and go to GO (back-to-back frames); otherwise go to IDLE with busy=0.
- Timing:
  - Latency from req rising in IDLE to ser_go is 1 cycle.
  - Go-to-Go spacing under continuous load is exactly FRAME_CYCLES.
- Requests arriving during GO/WAIT are not sampled; they wait for the end-of-frame arbitration. Requests are never lost, provided req stays high until ack.
- ser_a/ser_d change only on the cycle a new winner is loaded. They are stable from GO through the end of WAIT.
- Round-robin: search starts at pointer p, ascending with wrap (p, p+1, ..., NREQ-1, 0, ...). After a grant to i, p = (i+1) mod NREQ, so wrap from NREQ-1 goes to 0.
- A single requester holding req continuously is granted every FRAME_CYCLES.
- A requester that drops req before ack is simply skipped; no partial frame is issued.
- When req is all-zero at an arbitration point, the pointer is unchanged.

Optional Feature:
- Macro SERIAL_ARB_FIXED_PRIO_EN.
- When defined: fixed priority, lowest index wins, pointer logic removed.
- When undefined (default): round-robin as above.
- Timing is identical in both modes.

Decomposition:
- Shared package/include serial_out_pkg holds:
  - AW=7, DW=8, FRAME_CYCLES default 20
  - state encoding IDLE=2'd0, GO=2'd1, WAIT=2'd2
- Sub-module serial_rr_arbiter holds the combinational winner selection (req, pointer -> one-hot grant plus index).
- The FSM, counter, and A/D registers stay in the top module.

Test Plan:
- Reset, then drive req=4'b0001 with A=7'b1111111, D=8'hFF. Expect ser_go and ack[0] one cycle later, busy for 20 cycles, ser_a=7'h7F, ser_d=8'hFF stable. The serializer downstream must emit start 0, 1111111, Z, 11111111, Z, end 0.
- Drive req=4'b1111 continuously, with requester i using A=i+1, D=8'h10*i. Expect grants 0,1,2,3,0 exactly 20 cycles apart. ack must be one-hot and coincide with ser_go.
- In WAIT, with pointer=1, raise req=4'b1001. Expect no Go before cnt=0; the next grant goes to 3, then 0.
- Assert reset_n=0 at cycle 7 of a frame, release, then drive req=4'b0100. Expect all outputs 0 during reset, and Go to requester 2 one cycle after the req is seen after release.
- Pulse req[1] for 1 cycle during WAIT, dropped before the end. Expect no grant and a return to IDLE with busy=0.
- With SERIAL_ARB_FIXED_PRIO_EN defined and req=4'b1110 held, expect requester 1 granted every frame; 2 and 3 are never granted.

Source files
------------

// File: rtl/serial_out_pkg.sv
// Shared constants and state encoding for the serial output arbiter.
// Used by serial_out_arbiter and serial_rr_arbiter.
package serial_out_pkg;

  localparam int DEF_AW           = 7;
  localparam int DEF_DW           = 8;
  localparam int DEF_FRAME_CYCLES = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GO   = 2'd1,
    WAIT = 2'd2
  } arbState_e;

  // Index into a rotated request vector; never exceeds 2*n-2 on input.
  function automatic int wrapIndex(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/serial_rr_arbiter.sv
// Combinational winner selection: searches req ascending from ptr with wrap,
// returning a one-hot grant, its index and a valid flag.
module serial_rr_arbiter
  import serial_out_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grantIdx,
  output logic            grantValid
);

  int cand;

  always_comb begin
    grant      = '0;
    grantIdx   = '0;
    grantValid = 1'b0;
    cand       = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrapIndex(int'(ptr) + k, NREQ);
      if (!grantValid && req[cand]) begin
        grantValid  = 1'b1;
        grant[cand] = 1'b1;
        grantIdx    = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/serial_out_arbiter.sv
// Shares one A/D frame serializer between NREQ requesters, one Go per frame.
// Define SERIAL_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module serial_out_arbiter
  import serial_out_pkg::*;
#(
  parameter  int NREQ         = 4,
  parameter  int AW           = DEF_AW,
  parameter  int DW           = DEF_DW,
  parameter  int FRAME_CYCLES = DEF_FRAME_CYCLES,
  localparam int IDW          = $clog2(NREQ)
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_d,
  output logic [NREQ-1:0]      ack,
  output logic                 ser_go,
  output logic [AW-1:0]        ser_a,
  output logic [DW-1:0]        ser_d,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  localparam int CW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;

  arbState_e       state, stateNext;
  logic [CW-1:0]   cnt, cntNext;
  logic            arbFire;
  logic            busyNext;
  logic [NREQ-1:0] winGrant;
  logic [IDW-1:0]  winIdx;
  logic            winValid;
  logic [IDW-1:0]  searchBase;

  serial_rr_arbiter #(.NREQ(NREQ)) uArb (
    .req       (req),
    .ptr       (searchBase),
    .grant     (winGrant),
    .grantIdx  (winIdx),
    .grantValid(winValid)
  );

`ifdef SERIAL_ARB_FIXED_PRIO_EN
  assign searchBase = '0;
`else
  logic [IDW-1:0] rrPtr;

  // Pointer moves only on a grant, so an empty arbitration leaves it alone.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      rrPtr <= '0;
    end else if (arbFire) begin
      rrPtr <= (winIdx == IDW'(NREQ - 1)) ? '0 : winIdx + 1'b1;
    end
  end

  assign searchBase = rrPtr;
`endif

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    arbFire   = 1'b0;
    busyNext  = 1'b0;
    case (state)
      IDLE: begin
        arbFire = winValid;
      end
      GO: begin
        stateNext = WAIT;
        cntNext   = CW'(FRAME_CYCLES - 2);
        busyNext  = 1'b1;
      end
      WAIT: begin
        if (cnt == '0) begin
          arbFire   = winValid;
          stateNext = IDLE;
        end else begin
          cntNext  = cnt - 1'b1;
          busyNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (arbFire) begin
      stateNext = GO;
      busyNext  = 1'b1;
    end
  end

  // A/D and grant index load only when a winner is taken, holding them for the frame.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ser_go   <= 1'b0;
      ack      <= '0;
      busy     <= 1'b0;
      ser_a    <= '0;
      ser_d    <= '0;
      grant_id <= '0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      ser_go <= arbFire;
      ack    <= arbFire ? winGrant : '0;
      busy   <= busyNext;
      if (arbFire) begin
        ser_a    <= req_a[winIdx*AW +: AW];
        ser_d    <= req_d[winIdx*DW +: DW];
        grant_id <= winIdx;
      end
    end
  end

endmodule

// File: tb/tb_serial_out_arbiter.sv
// Scoreboard bench for serial_out_arbiter: expected grants are queued when
// requests are driven and checked as each Go appears.
module tb_serial_out_arbiter;

  localparam int NREQ  = 4;
  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int FRAME = 20;
  localparam int IDW   = 2;

  logic                 clk_in = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   req_a;
  logic [NREQ*DW-1:0]   req_d;
  logic [NREQ-1:0]      ack;
  logic                 ser_go;
  logic [AW-1:0]        ser_a;
  logic [DW-1:0]        ser_d;
  logic                 busy;
  logic [IDW-1:0]       grant_id;

  serial_out_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .FRAME_CYCLES(FRAME)
  ) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .req     (req),
    .req_a   (req_a),
    .req_d   (req_d),
    .ack     (ack),
    .ser_go  (ser_go),
    .ser_a   (ser_a),
    .ser_d   (ser_d),
    .busy    (busy),
    .grant_id(grant_id)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int id;
    int a;
    int d;
    int gap;
  } sbEntry_t;

  sbEntry_t    sbQ[$];
  sbEntry_t    sbHead;
  int          nCompared = 0;
  int          nMismatch = 0;
  int          cyc = 0;
  int          lastGo = 0;
  logic [AW-1:0] goA = '0;
  logic [DW-1:0] goD = '0;
  bit          autoDrop = 1'b0;
  int          aTab[NREQ];
  int          dTab[NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic loadTables();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*AW +: AW] = AW'(aTab[i]);
      req_d[i*DW +: DW] = DW'(dTab[i]);
    end
  endtask

  function automatic void pushExp(input int id, input int gap);
    sbEntry_t e;
    e.id  = id;
    e.a   = aTab[id];
    e.d   = dTab[id];
    e.gap = gap;
    sbQ.push_back(e);
  endfunction

  // Requesters drop their line on the cycle they see ack when autoDrop is set.
  task automatic tick();
    @(posedge clk_in);
    #1;
    if (autoDrop) req = req & ~ack;
  endtask

  task automatic waitGo();
    int b;
    b = 0;
    do begin
      tick();
      b++;
    end while (!ser_go && b < 100);
    chk("goSeen", 32'(ser_go), 32'd1);
  endtask

  task automatic waitIdle(input string tag);
    int b;
    b = 0;
    while (busy && b < 60) begin
      tick();
      b++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic chkZero(input string tag);
    chk({tag, "_ack"},   32'(ack),      32'd0);
    chk({tag, "_go"},    32'(ser_go),   32'd0);
    chk({tag, "_a"},     32'(ser_a),    32'd0);
    chk({tag, "_d"},     32'(ser_d),    32'd0);
    chk({tag, "_busy"},  32'(busy),     32'd0);
    chk({tag, "_gid"},   32'(grant_id), 32'd0);
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (reset_n && ser_go) begin
      chk("sbNonEmpty", 32'(sbQ.size() != 0), 32'd1);
      chk("busyAtGo", 32'(busy), 32'd1);
      if (sbQ.size() != 0) begin
        sbHead = sbQ.pop_front();
        chk("grantId", 32'(grant_id), 32'(sbHead.id));
        chk("serA", 32'(ser_a), 32'(sbHead.a));
        chk("serD", 32'(ser_d), 32'(sbHead.d));
        chk("ackOneHot", 32'(ack), 32'd1 << sbHead.id);
        if (sbHead.gap != 0) chk("goGap", 32'(cyc - lastGo), 32'(sbHead.gap));
      end
      lastGo = cyc;
      goA    = ser_a;
      goD    = ser_d;
    end else if (reset_n && busy) begin
      chk("aStable", 32'(ser_a), 32'(goA));
      chk("dStable", 32'(ser_d), 32'(goD));
      chk("ackQuiet", 32'(ack), 32'd0);
    end
  end

  initial begin
    int n;
    reset_n = 1'b0;
    req     = '0;
    for (int i = 0; i < NREQ; i++) begin
      aTab[i] = 0;
      dTab[i] = 0;
    end
    loadTables();
    repeat (3) tick();
    chkZero("rst0");
    reset_n = 1'b1;
    tick();

    // Single requester, all-ones payload
    aTab[0] = 7'h7F;
    dTab[0] = 8'hFF;
    loadTables();
    autoDrop = 1'b1;
    req = 4'b0001;
    pushExp(0, 0);
    tick();
    chk("lat1", 32'(ser_go), 32'd1);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    chk("busyLen", 32'(n), 32'(FRAME));

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // All four held continuously
    for (int i = 0; i < NREQ; i++) begin
      aTab[i] = i + 1;
      dTab[i] = 16 * i;
    end
    loadTables();
    autoDrop = 1'b0;
`ifdef SERIAL_ARB_FIXED_PRIO_EN
    pushExp(0, 0);
    repeat (4) pushExp(0, FRAME);
`else
    for (int i = 0; i < 5; i++) pushExp(i % NREQ, (i == 0) ? 0 : FRAME);
`endif
    req = 4'b1111;
    repeat (5) waitGo();
    req = 4'b0000;

    // Requests raised mid-frame wait for the end-of-frame arbitration
    repeat (3) tick();
    autoDrop = 1'b1;
`ifdef SERIAL_ARB_FIXED_PRIO_EN
    pushExp(0, FRAME);
    pushExp(3, FRAME);
`else
    pushExp(3, FRAME);
    pushExp(0, FRAME);
`endif
    req = 4'b1001;
    waitGo();
    waitGo();
    chk("reqCleared", 32'(req), 32'd0);

    // Short pulse during WAIT is never granted
    repeat (4) tick();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    waitIdle("pulseIdle");
    n = 0;
    repeat (25) begin
      tick();
      if (ser_go) n++;
    end
    chk("pulseNoGrant", 32'(n), 32'd0);

    // Reset in the middle of a frame
    pushExp(0, 0);
    req = 4'b0001;
    waitGo();
    repeat (6) tick();
    reset_n = 1'b0;
    tick();
    chkZero("rstMid");
    tick();
    chkZero("rstHold");
    reset_n = 1'b1;
    tick();
    pushExp(2, 0);
    req = 4'b0100;
    tick();
    chk("rstLat", 32'(ser_go), 32'd1);

    // Three held requesters after the grant to 2
    autoDrop = 1'b0;
    req = 4'b1110;
`ifdef SERIAL_ARB_FIXED_PRIO_EN
    repeat (3) pushExp(1, FRAME);
`else
    pushExp(3, FRAME);
    pushExp(1, FRAME);
    pushExp(2, FRAME);
`endif
    repeat (3) waitGo();
    req = 4'b0000;
    waitIdle("finalIdle");

    chk("sbDrained", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
